// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a halfword-organised data memory.
// A word spans entries a (upper half) and a+1 (lower half). Requests arrive over
// valid/ready, are sequenced through the one-cycle-latency memory (with a
// read-modify-write for halfword stores) and answered over valid/ready.
// Optional feature: define MEM_ACCESS_STATS_EN to add saturating 16-bit
// load/store/error response counters (o_stat_loads, o_stat_stores, o_stat_errs).
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic              i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_writedata,
  output logic              o_mem_write_en,
  output logic              o_mem_read_en,
  input  logic [DATA_W-1:0] i_mem_data
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]       o_stat_loads,
  output logic [15:0]       o_stat_stores,
  output logic [15:0]       o_stat_errs
`endif
);

  // Highest legal halfword index: a word needs entries a and a+1.
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(MEM_DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic                r_size;
  logic                r_signed;
  logic [15:0]         r_wdata_lo;
  logic                r_read_en;
  logic                r_write_en;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_writedata;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  // Extend the upper halfword of a memory word to a full load result.
  function automatic logic [DATA_W-1:0] f_ext_half(input logic [15:0] h, input logic sgn);
    if (sgn) begin
      f_ext_half = {{(DATA_W-16){h[15]}}, h};
    end else begin
      f_ext_half = {{(DATA_W-16){1'b0}}, h};
    end
  endfunction

  // Request sequencing FSM with all memory-side and response outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_we            <= 1'b0;
      r_size          <= 1'b0;
      r_signed        <= 1'b0;
      r_wdata_lo      <= 16'd0;
      r_read_en       <= 1'b0;
      r_write_en      <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_resp_valid    <= 1'b0;
      r_rdata         <= '0;
      r_err           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_signed   <= i_req_signed;
            r_wdata_lo <= i_req_wdata[15:0];
            r_rdata    <= '0;
            if (i_req_addr > LP_LAST_ADDR) begin
              // Out of range: answer immediately, memory never touched.
              r_err        <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (i_req_we && i_req_size) begin
              r_err           <= 1'b0;
              r_mem_address   <= i_req_addr;
              r_mem_writedata <= i_req_wdata;
              r_write_en      <= 1'b1;
              r_state         <= S_WRITE;
            end else begin
              // Loads and halfword stores both start with a read.
              r_err         <= 1'b0;
              r_mem_address <= i_req_addr;
              r_read_en     <= 1'b1;
              r_state       <= S_READ;
            end
          end
        end
        S_READ: begin
          r_read_en <= 1'b0;
          r_state   <= S_CAPT;
        end
        S_CAPT: begin
          if (r_we) begin
            // Merge new upper half with the untouched lower half.
            r_mem_writedata <= {r_wdata_lo, i_mem_data[15:0]};
            r_write_en      <= 1'b1;
            r_state         <= S_WRITE;
          end else begin
            if (r_size) begin
              r_rdata <= i_mem_data;
            end else begin
              r_rdata <= f_ext_half(i_mem_data[DATA_W-1:DATA_W-16], r_signed);
            end
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          r_write_en   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_read_en    <= 1'b0;
          r_write_en   <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Ready and memory strobes are forced low while reset is held.
  assign o_req_ready     = (r_state == S_IDLE) && !i_rst;
  assign o_mem_read_en   = r_read_en && !i_rst;
  assign o_mem_write_en  = r_write_en && !i_rst;
  assign o_mem_address   = r_mem_address;
  assign o_mem_writedata = r_mem_writedata;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_rdata    = r_rdata;
  assign o_resp_err      = r_err;

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] r_stat_loads;
  logic [15:0] r_stat_stores;
  logic [15:0] r_stat_errs;
  logic        w_resp_hs;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] f_sat_inc(input logic [15:0] c);
    if (c == 16'hFFFF) begin
      f_sat_inc = c;
    end else begin
      f_sat_inc = c + 16'd1;
    end
  endfunction

  assign w_resp_hs = r_resp_valid && i_resp_ready;

  // Count completed responses by kind on the response handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_loads  <= 16'd0;
      r_stat_stores <= 16'd0;
      r_stat_errs   <= 16'd0;
    end else if (w_resp_hs) begin
      if (r_err) begin
        r_stat_errs <= f_sat_inc(r_stat_errs);
      end else if (r_we) begin
        r_stat_stores <= f_sat_inc(r_stat_stores);
      end else begin
        r_stat_loads <= f_sat_inc(r_stat_loads);
      end
    end
  end

  assign o_stat_loads  = r_stat_loads;
  assign o_stat_stores = r_stat_stores;
  assign o_stat_errs   = r_stat_errs;
`endif

endmodule
